// File: rtl/usb_rx_decode.sv
// USB receive front end: line sync, bit recovery, NRZI decode, unstuffing, SYNC/EOP framing.
// Latency: 2 clk synchronizer + CLKS_PER_BIT/2 clk to the sample point; strobes one clk after the deciding sample.
// Backpressure: none, the serial line cannot be stalled; bytes and strobes must be consumed as they appear.
module usb_rx_decode #(
  parameter int CLKS_PER_BIT = 8,
  parameter int IDLE_BITS    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic       rx_active,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       eop,
  output logic       err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  // Line pair encoded as {D+, D-}
  localparam logic [1:0] L_J   = 2'b10;
  localparam logic [1:0] L_K   = 2'b01;
  localparam logic [1:0] L_SE0 = 2'b00;
  localparam logic [1:0] L_SE1 = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

  logic [1:0]    meta_q, line_q, line_prev_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_j_q, prev_j_d;      // previous J/K sample, 1 = J
  logic [7:0]    run_q, run_d;            // zeros in SYNC, consecutive J samples in ERROR
  logic [2:0]    ones_q, ones_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          partial_q, partial_d;    // EOP arrived with a partial byte
  logic          se0_seen_q, se0_seen_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          eop_q, eop_d;
  logic          err_q, err_d;

  logic       line_chg, sample, samp_j, is_jk, bit_dec;
  logic [7:0] shift_nxt;

  // Two-flop synchronizer plus one extra stage for edge detection; idles at J
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= L_J;
      line_q      <= L_J;
      line_prev_q <= L_J;
    end else begin
      meta_q      <= {d_plus, d_minus};
      line_q      <= meta_q;
      line_prev_q <= line_q;
    end
  end

  // Decode state and outputs register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      prev_j_q     <= 1'b1;
      run_q        <= '0;
      ones_q       <= '0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      partial_q    <= 1'b0;
      se0_seen_q   <= 1'b0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      eop_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prev_j_q     <= prev_j_d;
      run_q        <= run_d;
      ones_q       <= ones_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      partial_q    <= partial_d;
      se0_seen_q   <= se0_seen_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      eop_q        <= eop_d;
      err_q        <= err_d;
    end
  end

  // Bit recovery, NRZI decode, unstuffing and framing decisions
  always_comb begin
    state_d      = state_q;
    prev_j_d     = prev_j_q;
    run_d        = run_q;
    ones_d       = ones_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    partial_d    = partial_q;
    se0_seen_d   = se0_seen_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    eop_d        = 1'b0;
    err_d        = 1'b0;

    line_chg  = (line_q != line_prev_q);
    samp_j    = (line_q == L_J);
    is_jk     = samp_j || (line_q == L_K);
    bit_dec   = (samp_j == prev_j_q);
    shift_nxt = {bit_dec, shreg_q[7:1]};

    // Phase counter realigns to every line edge so the sample lands mid-cell
    if (state_q == S_IDLE || line_chg) cnt_d = '0;
    else if (cnt_q == LAST)            cnt_d = '0;
    else                               cnt_d = cnt_q + 1'b1;
    sample = (state_q != S_IDLE) && (cnt_q == HALF);

    case (state_q)
      S_IDLE: begin
        prev_j_d = 1'b1;
        run_d    = '0;
        if (line_q == L_K && line_prev_q == L_J) state_d = S_SYNC;
      end
      S_SYNC: if (sample) begin
        if (!is_jk) begin
          state_d = S_ERROR;
        end else begin
          prev_j_d = samp_j;
          if (!bit_dec) begin
            if (run_q != 8'hFF) run_d = run_q + 8'd1;
          end else if (run_q >= 8'd5) begin
            state_d  = S_DATA;
            ones_d   = '0;
            bitcnt_d = '0;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DATA: if (sample) begin
        if (line_q == L_SE0) begin
          state_d    = S_EOP;
          partial_d  = (bitcnt_q != 3'd0);
          se0_seen_d = 1'b0;
        end else if (line_q == L_SE1) begin
          state_d = S_ERROR;
        end else begin
          prev_j_d = samp_j;
          if (ones_q == 3'd6) begin
            // Stuff bit slot: a 0 is dropped, a 1 is a violation
            if (bit_dec) state_d = S_ERROR;
            else         ones_d  = '0;
          end else begin
            shreg_d = shift_nxt;
            ones_d  = bit_dec ? ones_q + 3'd1 : 3'd0;
            if (bitcnt_q == 3'd7) begin
              rx_byte_d    = shift_nxt;
              byte_valid_d = 1'b1;
              bitcnt_d     = '0;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
      end
      S_EOP: if (sample) begin
        if (line_q == L_SE0 && !se0_seen_q) begin
          se0_seen_d = 1'b1;
        end else if (samp_j && se0_seen_q) begin
          eop_d   = 1'b1;
          err_d   = partial_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_ERROR: if (sample) begin
        if (!samp_j)                            run_d = '0;
        else if (run_q == 8'(IDLE_BITS - 1))   state_d = S_IDLE;
        else                                    run_d = run_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Single err pulse on entering ERROR; the J-run count starts fresh
    if (state_d == S_ERROR && state_q != S_ERROR) begin
      err_d = 1'b1;
      run_d = '0;
    end
  end

  assign rx_active  = (state_q == S_SYNC) || (state_q == S_DATA) || (state_q == S_EOP);
  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign eop        = eop_q;
  assign err        = err_q;

endmodule
